// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between the instruction-fetch and
// data ports of the CPU. Data has priority over fetch; a small fairness
// counter guarantees fetch progress after a burst of data grants. Reads wait
// MEM_LAT cycles for memory, writes complete in the following cycle, and
// every access ends with a one-cycle response state.
module mem_arbiter #(
  parameter int MEM_LAT     = 2,
  parameter int MAX_D_BURST = 4
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  // instruction-fetch port
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  output logic        IF_gnt,
  output logic        IF_valid,
  output logic [31:0] IF_rdata,
  // data port
  input  logic        D_req,
  input  logic        D_we,
  input  logic [31:0] D_addr,
  input  logic [31:0] D_wdata,
  output logic        D_gnt,
  output logic        D_valid,
  output logic [31:0] D_rdata,
  // memory command / response
  output logic [31:0] MEM_addr,
  output logic [31:0] MEM_wdata,
  output logic        MEM_re,
  output logic        MEM_we,
  input  logic [31:0] MEM_rdata,
  // pipeline hold
  output logic        CPU_stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LAST  = 4'(MEM_LAT - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  state_t      state;
  state_t      state_nxt;
  logic        rst_done;   // set by the first rising edge seen out of reset
  logic [3:0]  fair_cnt;   // data grants issued while fetch was waiting
  logic [3:0]  wait_cnt;   // cycles spent in WAIT for the current read
  logic        own_d;      // current access belongs to the data port
  logic        gnt_if;
  logic        gnt_d;
  logic        wait_last;

  assign wait_last = (wait_cnt == LAT_LAST);

  // State register
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration: one grant per IDLE cycle, data first unless fetch has
  // been passed over MAX_D_BURST times in a row. Grants are held off until
  // a rising edge has been seen with reset released, so a request present
  // at release cannot be granted in the partial cycle before that edge.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if ((state == ST_IDLE) && rst_done) begin
      if (IF_req && (!D_req || (fair_cnt >= BURST_MAX))) begin
        gnt_if = 1'b1;
      end else if (D_req) begin
        gnt_d = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_if || (gnt_d && !D_we)) begin
          state_nxt = ST_WAIT;
        end else if (gnt_d) begin
          state_nxt = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (wait_last) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: memory command only in the grant cycle, valid pulses in RESP
  always_comb begin
    IF_gnt    = gnt_if;
    D_gnt     = gnt_d;
    MEM_re    = gnt_if | (gnt_d & ~D_we);
    MEM_we    = gnt_d & D_we;
    MEM_addr  = '0;
    MEM_wdata = '0;
    if (gnt_if) begin
      MEM_addr = IF_addr;
    end else if (gnt_d) begin
      MEM_addr  = D_addr;
      MEM_wdata = D_wdata;
    end
    IF_valid  = (state == ST_RESP) & ~own_d;
    D_valid   = (state == ST_RESP) & own_d;
    CPU_stall = (IF_req & ~((state == ST_RESP) & ~own_d))
              | (D_req  & ~((state == ST_RESP) & own_d));
  end

  // Reset-release qualifier for the arbiter
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // Fairness counter: counts data grants that made fetch wait
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      fair_cnt <= '0;
    end else if (gnt_if) begin
      fair_cnt <= '0;
    end else if (gnt_d) begin
      fair_cnt <= IF_req ? (fair_cnt + 4'd1) : '0;
    end
  end

  // Access bookkeeping: owner of the outstanding access and read latency count
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      wait_cnt <= '0;
      own_d    <= 1'b0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
      if (gnt_if || gnt_d) begin
        own_d <= gnt_d;
      end
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Read data capture on the edge that ends the last WAIT cycle
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      IF_rdata <= '0;
      D_rdata  <= '0;
    end else if ((state == ST_WAIT) && wait_last) begin
      if (own_d) begin
        D_rdata <= MEM_rdata;
      end else begin
        IF_rdata <= MEM_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a timeline model of the arbiter is checked
// against the DUT at every falling edge, alongside directed scenarios with
// literal expected values.
module tb_mem_arbiter;

  localparam int MEM_LAT     = 2;
  localparam int MAX_D_BURST = 4;

  logic        SYS_clk;
  logic        SYS_reset;
  logic        IF_req;
  logic [31:0] IF_addr;
  logic        IF_gnt;
  logic        IF_valid;
  logic [31:0] IF_rdata;
  logic        D_req;
  logic        D_we;
  logic [31:0] D_addr;
  logic [31:0] D_wdata;
  logic        D_gnt;
  logic        D_valid;
  logic [31:0] D_rdata;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_wdata;
  logic        MEM_re;
  logic        MEM_we;
  logic [31:0] MEM_rdata;
  logic        CPU_stall;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_D_BURST(MAX_D_BURST)) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .IF_req    (IF_req),
    .IF_addr   (IF_addr),
    .IF_gnt    (IF_gnt),
    .IF_valid  (IF_valid),
    .IF_rdata  (IF_rdata),
    .D_req     (D_req),
    .D_we      (D_we),
    .D_addr    (D_addr),
    .D_wdata   (D_wdata),
    .D_gnt     (D_gnt),
    .D_valid   (D_valid),
    .D_rdata   (D_rdata),
    .MEM_addr  (MEM_addr),
    .MEM_wdata (MEM_wdata),
    .MEM_re    (MEM_re),
    .MEM_we    (MEM_we),
    .MEM_rdata (MEM_rdata),
    .CPU_stall (CPU_stall)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  // memory contents as a function of address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  // memory: read data appears after the read strobe and holds until the next read
  logic [31:0] mem_q = '0;
  assign MEM_rdata = mem_q;
  always @(posedge SYS_clk) begin
    if (MEM_re) mem_q <= memfn(MEM_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int          cyc = 0;
  int          m_free = 0;      // first cycle a new grant may be issued
  int          m_done = 0;      // cycle of the pending response
  bit          m_pend = 0;
  bit          m_pend_d = 0;
  bit          m_pend_rd = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata = '0;
  int          m_burst = 0;
  bit          m_prev_rst = 0;

  always @(negedge SYS_clk) begin
    logic e_ig, e_dg, e_iv, e_dv, e_re, e_we, e_stall;
    logic [31:0] e_addr, e_wdata;
    cyc++;
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_re = 0; e_we = 0;
    e_addr = '0; e_wdata = '0;
    if (!SYS_reset) begin
      m_pend = 0; m_free = cyc; m_burst = 0;
      m_if_rdata = '0; m_d_rdata = '0;
      m_prev_rst = 0;
    end else begin
      if (m_pend && cyc == m_done) begin
        if (m_pend_d) begin
          e_dv = 1;
          if (m_pend_rd) m_d_rdata = m_data;
        end else begin
          e_iv = 1;
          m_if_rdata = m_data;
        end
        m_pend = 0;
      end
      if (m_prev_rst && cyc >= m_free) begin
        if (IF_req && (!D_req || m_burst == MAX_D_BURST)) begin
          e_ig = 1; e_re = 1; e_addr = IF_addr;
          m_pend = 1; m_pend_d = 0; m_pend_rd = 1;
          m_done = cyc + MEM_LAT + 1; m_free = cyc + MEM_LAT + 2;
          m_data = memfn(IF_addr);
          m_burst = 0;
        end else if (D_req) begin
          e_dg = 1; e_addr = D_addr; e_wdata = D_wdata;
          m_pend = 1; m_pend_d = 1; m_pend_rd = !D_we;
          if (D_we) begin
            e_we = 1; m_done = cyc + 1; m_free = cyc + 2;
          end else begin
            e_re = 1; m_done = cyc + MEM_LAT + 1; m_free = cyc + MEM_LAT + 2;
            m_data = memfn(D_addr);
          end
          m_burst = IF_req ? m_burst + 1 : 0;
        end
      end
      m_prev_rst = 1;
    end
    e_stall = (IF_req & ~e_iv) | (D_req & ~e_dv);
    chk("IF_gnt", IF_gnt, e_ig);
    chk("D_gnt", D_gnt, e_dg);
    chk("IF_valid", IF_valid, e_iv);
    chk("D_valid", D_valid, e_dv);
    chk("MEM_re", MEM_re, e_re);
    chk("MEM_we", MEM_we, e_we);
    chk("MEM_addr", MEM_addr, e_addr);
    chk("MEM_wdata", MEM_wdata, e_wdata);
    chk("IF_rdata", IF_rdata, m_if_rdata);
    chk("D_rdata", D_rdata, m_d_rdata);
    chk("CPU_stall", CPU_stall, e_stall);
  end

  // ---------------- directed stimulus ----------------
  task automatic step;
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge SYS_clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd, ni, d_before_if, nv;
    SYS_reset = 0; IF_req = 0; IF_addr = '0;
    D_req = 0; D_we = 0; D_addr = '0; D_wdata = '0;
    #2;
    chk("rst_IF_gnt", IF_gnt, 0);
    chk("rst_MEM_re", MEM_re, 0);
    chk("rst_IF_rdata", IF_rdata, 0);
    step(); step();

    // single fetch, request present at reset release
    SYS_reset = 1; IF_req = 1; IF_addr = 32'h40;
    at_neg(); chk("no_gnt_before_edge", IF_gnt, 0);
    step();
    at_neg();
    chk("fetch_gnt", IF_gnt, 1);
    chk("fetch_re", MEM_re, 1);
    chk("fetch_addr", MEM_addr, 32'h40);
    step(); at_neg(); chk("fetch_stall", CPU_stall, 1);
    step(); step(); at_neg();
    chk("fetch_valid", IF_valid, 1);
    chk("fetch_rdata", IF_rdata, 32'h8C01_0004);
    step(); IF_req = 0;
    step();

    // collision: data first, fetch at T+4
    D_req = 1; D_we = 0; D_addr = 32'h100; IF_req = 1; IF_addr = 32'h80;
    at_neg();
    chk("coll_d_gnt", D_gnt, 1);
    chk("coll_if_gnt", IF_gnt, 0);
    step(); step(); step(); at_neg();
    chk("coll_d_valid", D_valid, 1);
    chk("coll_d_rdata", D_rdata, 32'hA5A5_0100);
    step(); D_req = 0;
    at_neg(); chk("coll_if_gnt_t4", IF_gnt, 1);
    step(); at_neg(); chk("coll_stall", CPU_stall, 1);
    step(); step(); at_neg();
    chk("coll_if_rdata", IF_rdata, 32'hA5A5_0080);
    step(); IF_req = 0;
    step();

    // starvation guard: six data reads with fetch waiting
    IF_req = 1; IF_addr = 32'h200; D_req = 1; D_we = 0; D_addr = 32'h300;
    nd = 0; ni = 0; d_before_if = -1;
    for (int c = 0; c < 28; c++) begin
      if (c == 20) IF_req = 0;
      at_neg();
      if (D_gnt) nd++;
      if (IF_gnt) begin ni++; d_before_if = nd; end
      step();
    end
    D_req = 0;
    chk("burst_d_before_if", d_before_if, 4);
    chk("burst_d_total", nd, 6);
    chk("burst_if_total", ni, 1);
    step();

    // store, then back-to-back store
    D_req = 1; D_we = 1; D_addr = 32'h20; D_wdata = 32'hDEAD_BEEF;
    at_neg();
    chk("st_gnt", D_gnt, 1);
    chk("st_we", MEM_we, 1);
    chk("st_re", MEM_re, 0);
    chk("st_addr", MEM_addr, 32'h20);
    chk("st_wdata", MEM_wdata, 32'hDEAD_BEEF);
    step(); at_neg();
    chk("st_valid", D_valid, 1);
    chk("st_rdata_kept", D_rdata, 32'hA5A5_0300);
    step(); at_neg(); chk("st_b2b_gnt", D_gnt, 1);
    step(); at_neg(); chk("st_b2b_valid", D_valid, 1);
    step(); D_req = 0; D_we = 0;
    step();

    // withdraw: data pulse while fetch is waiting
    IF_req = 1; IF_addr = 32'h44;
    at_neg(); chk("wd_if_gnt", IF_gnt, 1);
    step();
    D_req = 1; D_we = 1; D_addr = 32'h24; D_wdata = 32'h1234;
    at_neg();
    chk("wd_no_gnt", D_gnt, 0);
    chk("wd_no_we", MEM_we, 0);
    step(); D_req = 0; D_we = 0;
    step(); at_neg(); chk("wd_if_rdata", IF_rdata, 32'hA5A5_0044);
    step(); IF_req = 0;
    step();

    // reset in the middle of a read
    IF_req = 1; IF_addr = 32'h48;
    at_neg(); chk("rr_gnt", IF_gnt, 1);
    step(); #2;
    SYS_reset = 0; IF_req = 0;
    #1;
    chk("rr_if_rdata", IF_rdata, 0);
    chk("rr_d_rdata", D_rdata, 0);
    chk("rr_valid", IF_valid, 0);
    chk("rr_stall", CPU_stall, 0);
    step(); SYS_reset = 1;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      at_neg();
      if (IF_valid) nv++;
      step();
    end
    chk("rr_no_valid", nv, 0);

    // data read after reset
    D_req = 1; D_we = 0; D_addr = 32'h104;
    at_neg(); chk("dr_gnt", D_gnt, 1);
    step(); step(); step(); at_neg();
    chk("dr_rdata", D_rdata, 32'hA5A5_0104);
    step(); D_req = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles, legal range 1..15.
REQ-002 Parameter MAX_D_BURST, default 4: maximum consecutive data grants while fetch is pending, legal range 1..15.
REQ-003 SYS_clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SYS_reset  in  1  reset, asynchronous, active-low.
REQ-005 IF_req  in  1  instruction-fetch read request, level.
REQ-006 IF_addr  in  32  fetch address, stable while IF_req is high.
REQ-007 IF_gnt  out  1  fetch grant pulse.
REQ-008 IF_valid  out  1  fetch data valid pulse.
REQ-009 IF_rdata  out  32  fetch data, registered.
REQ-010 D_req  in  1  data-port request, level.
REQ-011 D_we  in  1  1 = write, 0 = read; stable while D_req is high.
REQ-012 D_addr / D_wdata  in  32 / 32  data address and write data.
REQ-013 D_gnt  out  1  data grant pulse.
REQ-014 D_valid  out  1  data completion pulse.
REQ-015 D_rdata  out  32  load data, registered.
REQ-016 MEM_addr / MEM_wdata  out  32 / 32  memory command fields.
REQ-017 MEM_re / MEM_we  out  1 / 1  memory read and write strobes.
REQ-018 MEM_rdata  in  32  memory read data.
REQ-019 CPU_stall  out  1  PC and pipeline hold.

Function
REQ-020 The FSM SHALL have three states:
- IDLE: no access outstanding.
- WAIT: a read is outstanding, MEM_LAT cycles.
- RESP: one-cycle completion.
REQ-021 Grants SHALL be issued only in IDLE, at most one per cycle, and only to a requester whose req is high.
REQ-022 In the grant cycle T, the arbiter SHALL drive the granted requester's address (and for data, D_wdata) on MEM_addr/MEM_wdata and SHALL assert exactly one of MEM_re or MEM_we; in all other cycles MEM_re, MEM_we, MEM_addr and MEM_wdata SHALL be 0.
REQ-023 Read path:
- IDLE→WAIT after the grant.
- WAIT lasts cycles T+1..T+MEM_LAT.
- MEM_rdata is captured on the edge ending T+MEM_LAT.
- RESP is in cycle T+MEM_LAT+1, with the requester's *_rdata updated and *_valid=1.
REQ-024 Write path: IDLE→RESP after the grant; D_valid=1 in T+1; D_rdata unchanged.
REQ-025 RESP→IDLE unconditionally after one cycle; *_valid SHALL be a single-cycle pulse.
REQ-026 A req still high in the cycle after RESP SHALL be treated as a new request.
REQ-027 Priority SHALL be data over fetch when both are requesting in IDLE, subject to REQ-028.
REQ-028 Fairness counter (4 bits):
- Increments on each D grant made while IF_req is high.
- Clears on any IF grant, and clears when IF_req is low at a D grant.
- When the counter equals MAX_D_BURST and IF_req is high, the next grant SHALL go to fetch.
REQ-029 A req dropped before its grant SHALL receive no grant and cause no memory access.
REQ-030 Req changes during WAIT/RESP SHALL NOT affect the outstanding access.
REQ-031 CPU_stall SHALL equal (IF_req & ~IF_valid) | (D_req & ~D_valid), combinationally.
REQ-032 *_rdata SHALL hold its value until that port's next read completion.
REQ-033 Throughput: back-to-back reads SHALL complete every MEM_LAT+2 cycles; back-to-back writes every 2 cycles.

Reset
REQ-034 SYS_reset=0 SHALL immediately force the following, regardless of clock:
- state IDLE
- fairness counter 0
- all grant, valid and strobe outputs 0
- IF_rdata, D_rdata and MEM_addr/MEM_wdata 0
REQ-035 An access interrupted by reset SHALL be abandoned: no *_valid pulse after reset release for that access.
REQ-036 The first grant after reset release SHALL occur no earlier than the first rising edge with SYS_reset=1.

Verification
REQ-037 Single fetch: IF_req=1, IF_addr=0x40, memory returns 0x8C010004 at T+2 -> IF_gnt at T, MEM_re=1 with MEM_addr=0x40 at T, IF_valid=1 with IF_rdata=0x8C010004 at T+3.
REQ-038 Collision: IF_req and D_req (read, 0x100) rise in the same cycle -> D granted first, IF granted at T+4, CPU_stall=1 until IF_valid.
REQ-039 Starvation guard: D_req held high with 6 reads while IF_req=1 -> exactly 4 D grants, then an IF grant, then D resumes.
REQ-040 Store: D_we=1, D_addr=0x20, D_wdata=0xDEADBEEF -> MEM_we=1 with those values at T, D_valid at T+1, next grant possible at T+2, D_rdata unchanged.
REQ-041 Reset mid-read: assert SYS_reset=0 during WAIT -> outputs 0 asynchronously; after release, no IF_valid until a new grant.
REQ-042 Withdraw: D_req pulses for one cycle while a fetch is in WAIT -> no D_gnt and no MEM_we.
